// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath
// controls, and traps on illegal opcodes or data-memory handshake timeouts.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iInst_Code,
  input  logic        iData_Ready,
  output logic        oPC_En,
  output logic        oIR_En,
  output logic [3:0]  oALU_Control,
  output logic        oALUSrcMuxSel,
  output logic        oRegWrDataSel,
  output logic        oWrEn,
  output logic        oBranch,
  output logic        oData_Req,
  output logic        oData_WrEn,
  output logic        oIllegal,
  output logic        oBusErr,
  output logic [2:0]  oState
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    T_R, T_I, T_IL, T_S, T_B, T_ILL
  } itype_t;

  state_t           state, state_nxt;
  logic [6:0]       ir_opcode;
  logic [2:0]       ir_funct3;
  logic             ir_f7b5;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal_q, buserr_q;
  logic             set_illegal, set_buserr;
  logic             mem_timeout;
  itype_t           itype;

  // Only opcode, funct3 and funct7[5] steer control; register/immediate fields belong to the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{iInst_Code[31], iInst_Code[29:15], iInst_Code[11:7]};

  function automatic itype_t classify(input logic [6:0] op);
    case (op)
      OP_R:    classify = T_R;
      OP_I:    classify = T_I;
      OP_IL:   classify = T_IL;
      OP_S:    classify = T_S;
      OP_B:    classify = T_B;
      default: classify = T_ILL;
    endcase
  endfunction

  assign itype       = classify(ir_opcode);
  assign mem_timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= S_IDLE;
      ir_opcode <= '0;
      ir_funct3 <= '0;
      ir_f7b5   <= 1'b0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir_opcode <= iInst_Code[6:0];
        ir_funct3 <= iInst_Code[14:12];
        ir_f7b5   <= iInst_Code[30];
      end
      // Counter is zero everywhere outside MEM, so each MEM visit starts from 0.
      if (state == S_MEM && !iData_Ready)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_buserr)  buserr_q  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    set_illegal   = 1'b0;
    set_buserr    = 1'b0;
    oPC_En        = 1'b0;
    oIR_En        = 1'b0;
    oALU_Control  = 4'b0000;
    oALUSrcMuxSel = 1'b0;
    oRegWrDataSel = 1'b0;
    oWrEn         = 1'b0;
    oBranch       = 1'b0;
    oData_Req     = 1'b0;
    oData_WrEn    = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        oIR_En    = 1'b1;
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (itype == T_ILL) begin
          if (TRAP_ON_ILLEGAL) begin
            set_illegal = 1'b1;
            state_nxt   = S_TRAP;
          end else begin
            oPC_En    = 1'b1;
            state_nxt = S_FETCH;
          end
        end else begin
          state_nxt = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        state_nxt = S_FETCH;
        case (itype)
          T_R: begin
            oALU_Control = {ir_f7b5, ir_funct3};
            oWrEn        = 1'b1;
            oPC_En       = 1'b1;
          end
          T_I: begin
            // funct7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate data.
            oALU_Control  = {ir_f7b5 & (ir_funct3 == 3'b101), ir_funct3};
            oALUSrcMuxSel = 1'b1;
            oWrEn         = 1'b1;
            oPC_En        = 1'b1;
          end
          T_IL, T_S: begin
            oALUSrcMuxSel = 1'b1;
            state_nxt     = S_MEM;
          end
          T_B: begin
            oALU_Control = {1'b0, ir_funct3};
            oBranch      = 1'b1;
            oPC_En       = 1'b1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        oALUSrcMuxSel = 1'b1;
        oData_Req     = 1'b1;
        oData_WrEn    = (itype == T_S);
        // Ready is checked before timeout so a last-cycle completion still retires.
        if (iData_Ready) begin
          if (itype == T_S) begin
            oPC_En    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (mem_timeout) begin
          set_buserr = 1'b1;
          state_nxt  = S_TRAP;
        end
      end

      S_WB: begin
        oRegWrDataSel = 1'b1;
        oWrEn         = 1'b1;
        oPC_En        = 1'b1;
        state_nxt     = S_FETCH;
      end

      S_TRAP: state_nxt = S_TRAP;

      default: state_nxt = S_IDLE;
    endcase
  end

  assign oIllegal = illegal_q;
  assign oBusErr  = buserr_q;
  assign oState   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control vectors are queued
// as stimulus is driven and compared against the DUT on the falling edge.
module tb_multicycle_control_unit;

  logic        iClk;
  logic        iRst;
  logic [31:0] iInst_Code;
  logic        iData_Ready;
  logic        oPC_En, oIR_En, oALUSrcMuxSel, oRegWrDataSel, oWrEn, oBranch;
  logic        oData_Req, oData_WrEn, oIllegal, oBusErr;
  logic [3:0]  oALU_Control;
  logic [2:0]  oState;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic [3:0] alu;
    logic       src;
    logic       rsel;
    logic       wr;
    logic       br;
    logic       req;
    logic       dwr;
    logic       ill;
    logic       berr;
    logic [2:0] st;
  } obs_t;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_ill  = 1'b0;
  logic exp_berr = 1'b0;

  multicycle_control_unit #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iInst_Code    (iInst_Code),
    .iData_Ready   (iData_Ready),
    .oPC_En        (oPC_En),
    .oIR_En        (oIR_En),
    .oALU_Control  (oALU_Control),
    .oALUSrcMuxSel (oALUSrcMuxSel),
    .oRegWrDataSel (oRegWrDataSel),
    .oWrEn         (oWrEn),
    .oBranch       (oBranch),
    .oData_Req     (oData_Req),
    .oData_WrEn    (oData_WrEn),
    .oIllegal      (oIllegal),
    .oBusErr       (oBusErr),
    .oState        (oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic obs_t mk(input logic [2:0] st, input logic pc, input logic ir,
                              input logic [3:0] alu, input logic src, input logic rsel,
                              input logic wr, input logic br, input logic req, input logic dwr);
    obs_t e;
    e = '{pc_en: pc, ir_en: ir, alu: alu, src: src, rsel: rsel, wr: wr, br: br,
          req: req, dwr: dwr, ill: exp_ill, berr: exp_berr, st: st};
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o = '{pc_en: oPC_En, ir_en: oIR_En, alu: oALU_Control, src: oALUSrcMuxSel,
          rsel: oRegWrDataSel, wr: oWrEn, br: oBranch, req: oData_Req, dwr: oData_WrEn,
          ill: oIllegal, berr: oBusErr, st: oState};
    return o;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic cyc(input logic rdy, input obs_t e, input string tag);
    obs_t got, exp;
    iData_Ready = rdy;
    q.push_back(e);
    @(negedge iClk);
    got = observed();
    exp = q.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    @(posedge iClk);
    #1;
  endtask

  // FETCH then DECODE; the instruction bus is scrambled after FETCH to prove it is latched.
  task automatic fetch_decode(input logic [31:0] inst, input string tag);
    iInst_Code = inst;
    cyc(1'b1, mk(3'd1, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0), {tag, "_fetch"});
    iInst_Code = 32'h0000_0000;
    cyc(1'b1, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), {tag, "_decode"});
  endtask

  task automatic do_reset(input string tag);
    iRst = 1'b1;
    exp_ill  = 1'b0;
    exp_berr = 1'b0;
    cyc(1'b0, mk(3'd0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), {tag, "_rst"});
    iRst = 1'b0;
    cyc(1'b0, mk(3'd0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), {tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst        = 1'b1;
    iInst_Code  = 32'h0;
    iData_Ready = 1'b0;
    @(posedge iClk);
    @(posedge iClk);
    #1;
    do_reset("init");

    // add x3,x1,x2
    fetch_decode(32'h002081B3, "add");
    cyc(1'b0, mk(3'd3, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 0), "add_exec");

    // srai x5,x1,2
    fetch_decode(32'h4020D293, "srai");
    cyc(1'b0, mk(3'd3, 1, 0, 4'b1101, 1, 0, 1, 0, 0, 0), "srai_exec");

    // addi x1,x0,-1024: immediate bit 30 set but must not select SUB
    fetch_decode(32'hC0000093, "addi");
    cyc(1'b0, mk(3'd3, 1, 0, 4'b0000, 1, 0, 1, 0, 0, 0), "addi_exec");

    // lw x5,4(x1), ready on third MEM cycle
    fetch_decode(32'h0040A283, "lw");
    cyc(1'b0, mk(3'd3, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0), "lw_exec");
    cyc(1'b0, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), "lw_mem1");
    cyc(1'b0, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), "lw_mem2");
    cyc(1'b1, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), "lw_mem3");
    cyc(1'b0, mk(3'd5, 1, 0, 4'h0, 0, 1, 1, 0, 0, 0), "lw_wb");

    // sw x2,8(x1), ready on first MEM cycle
    fetch_decode(32'h0020A423, "sw");
    cyc(1'b0, mk(3'd3, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0), "sw_exec");
    cyc(1'b1, mk(3'd4, 1, 0, 4'h0, 1, 0, 0, 0, 1, 1), "sw_mem");

    // beq x1,x1,8
    fetch_decode(32'h00108463, "beq");
    cyc(1'b0, mk(3'd3, 1, 0, 4'b0000, 0, 0, 0, 1, 0, 0), "beq_exec");

    // lw with ready never asserted: 16 MEM cycles then bus-error trap
    fetch_decode(32'h0040A283, "lwto");
    cyc(1'b0, mk(3'd3, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0), "lwto_exec");
    for (int i = 0; i < 16; i++)
      cyc(1'b0, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), $sformatf("lwto_mem%0d", i + 1));
    exp_berr = 1'b1;
    cyc(1'b0, mk(3'd7, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "lwto_trap");
    cyc(1'b1, mk(3'd7, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "lwto_trap_hold1");
    cyc(1'b0, mk(3'd7, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "lwto_trap_hold2");
    do_reset("berr_clr");

    // Reset pulsed mid-MEM
    fetch_decode(32'h0040A283, "lwrst");
    cyc(1'b0, mk(3'd3, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0), "lwrst_exec");
    cyc(1'b0, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), "lwrst_mem1");
    cyc(1'b0, mk(3'd4, 0, 0, 4'h0, 1, 0, 0, 0, 1, 0), "lwrst_mem2");
    do_reset("midmem");

    // Illegal opcode traps and stays trapped
    iInst_Code = 32'hFFFFFFFF;
    cyc(1'b0, mk(3'd1, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0), "ill_fetch");
    cyc(1'b0, mk(3'd2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "ill_decode");
    exp_ill = 1'b1;
    iInst_Code = 32'h002081B3;
    cyc(1'b1, mk(3'd7, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "ill_trap");
    cyc(1'b0, mk(3'd7, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0), "ill_trap_hold");
    do_reset("ill_clr");

    // Normal operation resumes after trap recovery
    fetch_decode(32'h002081B3, "add2");
    cyc(1'b0, mk(3'd3, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 0), "add2_exec");
    cyc(1'b0, mk(3'd1, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0), "add2_next_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
